trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Machine-mode trap controller for the pipelined core.
- Accepts synchronous exceptions (MEM stage), external interrupts and MRET.
- Squashes younger stages and holds fetch while older instructions drain.
- Pulses the CSR file for mepc/mcause/mstatus updates, then redirects the PC to the trap vector or to mepc.
- Sits beside the hazard unit: its squash and hold outputs are ORed into the hazard unit's squash and stall paths.

Parameters:
- DRAIN_CYCLES, 2, cycles spent in DRAIN so instructions in MEM/WB retire before CSR writes (legal range 1..15).
- INT_CAUSE, 11, mcause code for machine external interrupt.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- stall_n  in  1  hazard-unit stall, active low; a trap or MRET is accepted only when high.
- exc_valid  in  1  valid exception on the MEM-stage instruction.
- exc_cause  in  4  exception code.
- exc_pc  in  32  PC of the faulting MEM instruction.
- ex_pc  in  32  PC of the EX-stage instruction (the interrupt return point).
- ex_valid  in  1  EX stage holds an unsquashed instruction.
- intr  in  1  external interrupt request, level.
- mie  in  1  mstatus.MIE.
- mtvec  in  32  trap vector CSR.
- mepc_in  in  32  current mepc CSR.
- mret_req  in  1  MRET in EX stage.
- squash_o  out  4  squash bits {WB,MEM,EX,DE}.
- fetch_hold  out  1  freeze PC/fetch.
- trap_enter  out  1  CSR pulse: write mepc/mcause, MPIE<=MIE, MIE<=0.
- trap_exit  out  1  CSR pulse: MIE<=MPIE, MPIE<=1.
- mepc_wdata  out  32  value for mepc.
- mcause_wdata  out  32  value for mcause.
- pc_redirect  out  1  load redirect_pc into the PC.
- redirect_pc  out  32  target PC.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, SQUASH, DRAIN, SAVE, REDIRECT, RETURN.
- All outputs are registered-state decodes. Every output is 0 in IDLE and after reset.
- Reset: any state -> IDLE. The drain counter clears. No CSR pulse or redirect is issued for an aborted sequence.
- IDLE accept requires stall_n=1. Priority is exc_valid > (intr & mie & ex_valid) > mret_req. Lower-priority requests in the same cycle are dropped; intr stays pending by level.
- Exception accept:
  - mepc_reg<=exc_pc.
  - mcause_reg<={1'b0,27'b0,exc_cause}.
  - sq_reg<=4'b0111 (squashes DE, EX and MEM; the faulting instruction must not retire).
  - Next state SQUASH.
- Interrupt accept:
  - mepc_reg<=ex_pc.
  - mcause_reg<={1'b1,27'b0,INT_CAUSE[3:0]}.
  - sq_reg<=4'b0011.
  - Next state SQUASH.
- MRET accept: sq_reg<=4'b0011; next state RETURN.
- SQUASH (1 cycle):
  - squash_o=sq_reg, fetch_hold=1.
  - cnt<=DRAIN_CYCLES-1; next state DRAIN.
- DRAIN:
  - fetch_hold=1, squash_o=0.
  - cnt decrements each cycle; at cnt==0 go to SAVE. Total DRAIN_CYCLES cycles.
- SAVE (1 cycle): fetch_hold=1, trap_enter=1, mepc_wdata=mepc_reg, mcause_wdata=mcause_reg. Next state REDIRECT.
- REDIRECT (1 cycle):
  - fetch_hold=1, pc_redirect=1.
  - redirect_pc={mtvec[31:2],2'b00} by default.
  - If mtvec[1:0]==2'b01 and mcause_reg[31]=1: redirect_pc={mtvec[31:2],2'b00}+(mcause_reg[3:0]<<2). 32-bit wrap allowed.
  - Next state IDLE.
- RETURN (1 cycle):
  - squash_o=sq_reg, trap_exit=1, pc_redirect=1, redirect_pc={mepc_in[31:2],2'b00}, fetch_hold=1.
  - Next state IDLE.
- Request inputs are ignored while busy=1; exceptions from squashed or younger instructions are discarded.
- mepc_wdata and mcause_wdata hold their last value outside SAVE.
- Latency:
  - Exception or interrupt accept to pc_redirect = DRAIN_CYCLES+3 cycles.
  - MRET accept to pc_redirect = 1 cycle.
- Back-to-back: a request present in the cycle after REDIRECT/RETURN is evaluated normally in IDLE.

Test Plan:
- Reset with DRAIN_CYCLES=2 -> all outputs 0, busy=0. Assert RST in DRAIN -> next cycle IDLE, trap_enter never pulses.
- exc_valid=1, exc_cause=2, exc_pc=0x0000_0104, mtvec=0x0000_0200, stall_n=1 -> squash_o=0111 at +1, DRAIN +2..+3, trap_enter at +4 with mepc_wdata=0x104 and mcause_wdata=0x2, pc_redirect at +5 with redirect_pc=0x200, busy=0 at +6.
- intr=1, mie=1, ex_valid=1, ex_pc=0x0000_0040, mtvec=0x0000_0301 -> squash_o=0011, mcause_wdata=0x8000_000B, redirect_pc=0x0000_032C.
- intr=1, mie=1, exc_valid=1, mret_req=1 in the same cycle -> exception path taken, mcause[31]=0. Also intr=1 with mie=0 -> no accept, busy stays 0.
- mret_req=1, mepc_in=0x0000_0106 -> next cycle trap_exit=1, squash_o=0011, pc_redirect=1, redirect_pc=0x0000_0104.
- exc_valid=1 with stall_n=0 for 3 cycles, then stall_n=1 -> accept only in the cycle stall_n rises. A second exc_valid during DRAIN is ignored and only one trap_enter is issued.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap controller.
// Accepts a MEM-stage exception, an external interrupt or an MRET while idle.
// For traps it squashes the younger stages, holds fetch while older
// instructions drain, pulses the CSR file and then redirects the PC to the
// trap vector. For MRET it squashes, pulses the CSR file and redirects the PC
// to mepc in a single cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no sequence in flight; requests are evaluated here
// SQUASH   | one cycle: squash the captured stages, hold fetch
// DRAIN    | DRAIN_CYCLES cycles: older instructions retire, fetch held
// SAVE     | one cycle: trap_enter pulse with mepc/mcause write data
// REDIRECT | one cycle: load the trap vector into the PC
// RETURN   | one cycle: MRET squash, trap_exit pulse, PC <- mepc
module trap_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int INT_CAUSE    = 11
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] ex_pc,
  input  logic        ex_valid,
  input  logic        intr,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_in,
  input  logic        mret_req,
  output logic [3:0]  squash_o,
  output logic        fetch_hold,
  output logic        trap_enter,
  output logic        trap_exit,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SQUASH   = 3'd1,
    S_DRAIN    = 3'd2,
    S_SAVE     = 3'd3,
    S_REDIRECT = 3'd4,
    S_RETURN   = 3'd5
  } state_t;

  // Drain counter preload: the counter runs DRAIN_CYCLES-1 down to 0.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] INT_CODE   = 4'(INT_CAUSE);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sq_q, sq_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mepc_wdata_q, mepc_wdata_d;
  logic [31:0] mcause_wdata_q, mcause_wdata_d;

  logic        int_take;
  logic [31:0] vec_base;
  logic [31:0] vec_pc;

  assign int_take = intr & mie & ex_valid;

  // Vector base is mtvec with the mode bits cleared; vectored mode adds
  // cause*4 for interrupts only. Addition wraps at 32 bits.
  assign vec_base = mtvec & 32'hFFFF_FFFC;
  assign vec_pc   = ((mtvec[1:0] == 2'b01) && mcause_q[31])
                    ? (vec_base + {26'd0, mcause_q[3:0], 2'b00})
                    : vec_base;

  // State and capture registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      sq_q           <= 4'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mepc_wdata_q   <= 32'd0;
      mcause_wdata_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sq_q           <= sq_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mepc_wdata_q   <= mepc_wdata_d;
      mcause_wdata_q <= mcause_wdata_d;
    end
  end

  // Next-state logic, request arbitration and capture of trap context.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sq_d           = sq_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mepc_wdata_d   = mepc_wdata_q;
    mcause_wdata_d = mcause_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (stall_n) begin
          if (exc_valid) begin
            // The faulting instruction sits in MEM and must not retire.
            mepc_d   = exc_pc;
            mcause_d = {1'b0, 27'd0, exc_cause};
            sq_d     = 4'b0111;
            state_d  = S_SQUASH;
          end else if (int_take) begin
            // EX instruction becomes the return point; MEM/WB drain.
            mepc_d   = ex_pc;
            mcause_d = {1'b1, 27'd0, INT_CODE};
            sq_d     = 4'b0011;
            state_d  = S_SQUASH;
          end else if (mret_req) begin
            sq_d    = 4'b0011;
            state_d = S_RETURN;
          end
        end
      end
      S_SQUASH: begin
        cnt_d   = DRAIN_INIT;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0) begin
          // Write data is loaded on entry to SAVE and then held.
          mepc_wdata_d   = mepc_q;
          mcause_wdata_d = mcause_q;
          state_d        = S_SAVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAVE:     state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      S_RETURN:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    squash_o    = 4'd0;
    fetch_hold  = 1'b0;
    trap_enter  = 1'b0;
    trap_exit   = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'd0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_SQUASH: begin
        squash_o   = sq_q;
        fetch_hold = 1'b1;
      end
      S_DRAIN: begin
        fetch_hold = 1'b1;
      end
      S_SAVE: begin
        fetch_hold = 1'b1;
        trap_enter = 1'b1;
      end
      S_REDIRECT: begin
        fetch_hold  = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = vec_pc;
      end
      S_RETURN: begin
        squash_o    = sq_q;
        fetch_hold  = 1'b1;
        trap_exit   = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = mepc_in & 32'hFFFF_FFFC;
      end
      default: begin
      end
    endcase
  end

  assign mepc_wdata   = mepc_wdata_q;
  assign mcause_wdata = mcause_wdata_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a scoreboard of expected CSR
// writes and PC redirects checked by a monitor.
module tb_trap_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall_n;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] ex_pc;
  logic        ex_valid;
  logic        intr;
  logic        mie;
  logic [31:0] mtvec;
  logic [31:0] mepc_in;
  logic        mret_req;
  logic [3:0]  squash_o;
  logic        fetch_hold;
  logic        trap_enter;
  logic        trap_exit;
  logic [31:0] mepc_wdata;
  logic [31:0] mcause_wdata;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] mepc;
    logic [31:0] mcause;
  } enter_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        is_exit;
  } redir_t;

  enter_t enter_q[$];
  redir_t redir_q[$];

  trap_sequencer #(.DRAIN_CYCLES(2), .INT_CAUSE(11)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .stall_n      (stall_n),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_pc       (exc_pc),
    .ex_pc        (ex_pc),
    .ex_valid     (ex_valid),
    .intr         (intr),
    .mie          (mie),
    .mtvec        (mtvec),
    .mepc_in      (mepc_in),
    .mret_req     (mret_req),
    .squash_o     (squash_o),
    .fetch_hold   (fetch_hold),
    .trap_enter   (trap_enter),
    .trap_exit    (trap_exit),
    .mepc_wdata   (mepc_wdata),
    .mcause_wdata (mcause_wdata),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    exc_valid = 1'b0;
    intr      = 1'b0;
    mret_req  = 1'b0;
    ex_valid  = 1'b0;
  endtask

  // Scoreboard side: every CSR pulse and redirect must match the oldest
  // outstanding expectation.
  always @(negedge CLK) begin
    if (!RST) begin
      if (trap_enter) begin
        if (enter_q.size() == 0) begin
          chk("unexpected_trap_enter", 32'd1, 32'd0);
        end else begin
          enter_t e;
          e = enter_q.pop_front();
          chk("sb_mepc_wdata", mepc_wdata, e.mepc);
          chk("sb_mcause_wdata", mcause_wdata, e.mcause);
        end
      end
      if (pc_redirect) begin
        if (redir_q.size() == 0) begin
          chk("unexpected_pc_redirect", 32'd1, 32'd0);
        end else begin
          redir_t r;
          r = redir_q.pop_front();
          chk("sb_redirect_pc", redirect_pc, r.pc);
          chk("sb_trap_exit", {31'd0, trap_exit}, {31'd0, r.is_exit});
        end
      end
    end
  end

  initial begin
    RST = 1'b1; stall_n = 1'b1; clear_req();
    exc_cause = 4'd0; exc_pc = 32'd0; ex_pc = 32'd0; mie = 1'b0;
    mtvec = 32'd0; mepc_in = 32'd0;

    // Reset state
    tick(); tick();
    chk("rst_squash", {28'd0, squash_o}, 32'd0);
    chk("rst_hold", {31'd0, fetch_hold}, 32'd0);
    chk("rst_enter", {31'd0, trap_enter}, 32'd0);
    chk("rst_exit", {31'd0, trap_exit}, 32'd0);
    chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_mepc_wdata", mepc_wdata, 32'd0);
    chk("rst_mcause_wdata", mcause_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    RST = 1'b0;
    tick();

    // Synchronous exception, full timeline
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h0000_0104; mtvec = 32'h0000_0200;
    enter_q.push_back('{mepc: 32'h104, mcause: 32'h2});
    redir_q.push_back('{pc: 32'h200, is_exit: 1'b0});
    tick(); clear_req();
    chk("exc_p1_squash", {28'd0, squash_o}, 32'h7);
    chk("exc_p1_hold", {31'd0, fetch_hold}, 32'd1);
    chk("exc_p1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("exc_p2_squash", {28'd0, squash_o}, 32'd0);
    chk("exc_p2_hold", {31'd0, fetch_hold}, 32'd1);
    chk("exc_p2_enter", {31'd0, trap_enter}, 32'd0);
    tick();
    chk("exc_p3_enter", {31'd0, trap_enter}, 32'd0);
    tick();
    chk("exc_p4_enter", {31'd0, trap_enter}, 32'd1);
    chk("exc_p4_mepc", mepc_wdata, 32'h104);
    chk("exc_p4_mcause", mcause_wdata, 32'h2);
    tick();
    chk("exc_p5_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("exc_p5_pc", redirect_pc, 32'h200);
    chk("exc_p5_enter", {31'd0, trap_enter}, 32'd0);
    tick();
    chk("exc_p6_busy", {31'd0, busy}, 32'd0);
    chk("exc_p6_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("exc_p6_hold", {31'd0, fetch_hold}, 32'd0);

    // Interrupt with vectored mtvec
    intr = 1'b1; mie = 1'b1; ex_valid = 1'b1; ex_pc = 32'h0000_0040; mtvec = 32'h0000_0301;
    enter_q.push_back('{mepc: 32'h40, mcause: 32'h8000_000B});
    redir_q.push_back('{pc: 32'h32C, is_exit: 1'b0});
    tick(); clear_req();
    chk("int_squash", {28'd0, squash_o}, 32'h3);
    tick(); tick(); tick();
    chk("int_enter", {31'd0, trap_enter}, 32'd1);
    chk("int_mcause", mcause_wdata, 32'h8000_000B);
    tick();
    chk("int_redirect_pc", redirect_pc, 32'h32C);
    tick();

    // Priority: exception beats interrupt and MRET; sync cause not vectored
    intr = 1'b1; mie = 1'b1; ex_valid = 1'b1; mret_req = 1'b1;
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h0000_0208; mtvec = 32'h0000_0201;
    enter_q.push_back('{mepc: 32'h208, mcause: 32'h5});
    redir_q.push_back('{pc: 32'h200, is_exit: 1'b0});
    tick(); clear_req();
    chk("prio_squash", {28'd0, squash_o}, 32'h7);
    tick(); tick(); tick();
    chk("prio_mcause31", {31'd0, mcause_wdata[31]}, 32'd0);
    tick();
    chk("prio_redirect_pc", redirect_pc, 32'h200);
    tick();

    // Interrupt masked by mie=0
    intr = 1'b1; mie = 1'b0; ex_valid = 1'b1;
    tick();
    chk("masked_busy1", {31'd0, busy}, 32'd0);
    tick();
    chk("masked_busy2", {31'd0, busy}, 32'd0);
    clear_req(); mie = 1'b1;

    // MRET
    mret_req = 1'b1; mepc_in = 32'h0000_0106;
    redir_q.push_back('{pc: 32'h104, is_exit: 1'b1});
    tick(); clear_req();
    chk("mret_exit", {31'd0, trap_exit}, 32'd1);
    chk("mret_squash", {28'd0, squash_o}, 32'h3);
    chk("mret_redirect", {31'd0, pc_redirect}, 32'd1);
    chk("mret_pc", redirect_pc, 32'h104);
    chk("mret_hold", {31'd0, fetch_hold}, 32'd1);
    tick();
    chk("mret_done_busy", {31'd0, busy}, 32'd0);
    chk("mret_done_exit", {31'd0, trap_exit}, 32'd0);

    // Stall blocks accept; second exception during DRAIN ignored
    exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h0000_0300; mtvec = 32'h0000_0400;
    stall_n = 1'b0;
    tick(); chk("stall_busy1", {31'd0, busy}, 32'd0);
    tick(); chk("stall_busy2", {31'd0, busy}, 32'd0);
    tick(); chk("stall_busy3", {31'd0, busy}, 32'd0);
    stall_n = 1'b1;
    enter_q.push_back('{mepc: 32'h300, mcause: 32'h4});
    redir_q.push_back('{pc: 32'h400, is_exit: 1'b0});
    tick();
    chk("stall_accept_busy", {31'd0, busy}, 32'd1);
    chk("stall_accept_squash", {28'd0, squash_o}, 32'h7);
    tick();
    exc_pc = 32'h0000_0500; exc_cause = 4'd6;
    tick();
    clear_req();
    tick();
    chk("stall_mepc", mepc_wdata, 32'h300);
    tick(); tick();
    chk("stall_idle", {31'd0, busy}, 32'd0);

    // Reset in DRAIN aborts without CSR pulse
    exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h0000_0600;
    tick(); clear_req();
    tick();
    chk("abort_in_drain", {31'd0, fetch_hold}, 32'd1);
    RST = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mepc_wdata", mepc_wdata, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_enter", {31'd0, trap_enter}, 32'd0);
    end

    // Back-to-back: MRET held through REDIRECT is taken in the following IDLE cycle
    exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h0000_0700; mtvec = 32'h0000_0800;
    mepc_in = 32'h0000_0080;
    enter_q.push_back('{mepc: 32'h700, mcause: 32'h3});
    redir_q.push_back('{pc: 32'h800, is_exit: 1'b0});
    redir_q.push_back('{pc: 32'h80, is_exit: 1'b1});
    tick(); clear_req();
    tick(); tick(); tick(); tick();
    mret_req = 1'b1;
    chk("b2b_redirect", {31'd0, pc_redirect}, 32'd1);
    tick();
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    tick(); clear_req();
    chk("b2b_exit", {31'd0, trap_exit}, 32'd1);
    chk("b2b_pc", redirect_pc, 32'h80);
    tick();

    chk("sb_enter_drained", enter_q.size(), 32'd0);
    chk("sb_redir_drained", redir_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
